// File: rtl/hazard_scoreboard.sv
// Purpose: tracks destination tags through EX..WB to stall dependent stages and pick forward sources per read port.
// Latency: stall/fwd_sel are combinational from registered tags and current inputs; tags advance every clock.
// Backpressure: a stalled stage holds its tag and hands a bubble downstream; stall ripples toward ID.
// Optional: define HAZ_LONGOP_EN to build the multi-cycle HI/LO down-counter and its read-port interlock.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int STAGE_BITS = 2,
    parameter int REG_BITS   = 5,
    parameter int NUM_READ   = 4,
    parameter int LONG_BITS  = 6
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           id_issue,
    input  logic                           id_regwrite,
    input  logic [REG_BITS-1:0]            id_dst,
    input  logic [STAGE_BITS-1:0]          id_rdy,
    input  logic                           flush_ex,
    input  logic [DEPTH:0]                 stall_req,
    input  logic [NUM_READ*REG_BITS-1:0]   rd_reg,
    input  logic [NUM_READ*STAGE_BITS-1:0] rd_stage,
    input  logic [NUM_READ-1:0]            rd_want,
    input  logic [NUM_READ-1:0]            rd_need,
    input  logic [NUM_READ-1:0]            rd_long,
    input  logic                           longop_start,
    input  logic [LONG_BITS-1:0]           longop_cycles,
    output logic [DEPTH:0]                 stall,
    output logic [NUM_READ*STAGE_BITS-1:0] fwd_sel,
    output logic                           longop_busy
);

    typedef struct packed {
        logic                  v;
        logic [REG_BITS-1:0]   dst;
        logic [STAGE_BITS-1:0] rdy;
    } tag_t;

    tag_t                  tags [1:DEPTH];
    tag_t                  id_tag;
    logic [NUM_READ-1:0]   port_stall;
    logic [NUM_READ-1:0]   hit;
    logic [NUM_READ-1:0]   hit_ready;
    logic [STAGE_BITS-1:0] hit_stage [NUM_READ];
    logic [DEPTH-1:0]      hazard_stall;
    logic                  long_block;

    assign id_tag = '{v: id_issue & id_regwrite, dst: id_dst, rdy: id_rdy};

`ifdef HAZ_LONGOP_EN
    logic [LONG_BITS-1:0] long_cnt;

    // Long-op down-counter: a start (even while busy) reloads, otherwise count down to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            long_cnt <= '0;
        end else if (longop_start) begin
            long_cnt <= longop_cycles;
        end else if (long_cnt != '0) begin
            long_cnt <= long_cnt - 1'b1;
        end
    end

    assign long_block  = (long_cnt != '0);
    assign longop_busy = long_block;
`else
    logic unused_longop;
    assign unused_longop = longop_start ^ (^longop_cycles);
    assign long_block    = 1'b0;
    assign longop_busy   = 1'b0;
`endif

    // Per-port scan: walk from the oldest stage toward the reader so the last hit kept is the nearest one.
    always_comb begin
        fwd_sel    = '0;
        port_stall = '0;
        hit        = '0;
        hit_ready  = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            hit_stage[p] = '0;
            for (int s = DEPTH; s >= 1; s--) begin
                if (tags[s].v && (tags[s].dst != '0) &&
                    (tags[s].dst == rd_reg[p*REG_BITS +: REG_BITS]) &&
                    (STAGE_BITS'(s) > rd_stage[p*STAGE_BITS +: STAGE_BITS])) begin
                    hit[p]       = 1'b1;
                    hit_stage[p] = STAGE_BITS'(s);
                    hit_ready[p] = (STAGE_BITS'(s) >= tags[s].rdy);
                end
            end
            if (hit[p] && (rd_want[p] || rd_need[p])) begin
                if (hit_ready[p]) begin
                    fwd_sel[p*STAGE_BITS +: STAGE_BITS] = hit_stage[p];
                end else if (rd_need[p]) begin
                    port_stall[p] = 1'b1;
                end
            end
            if (rd_long[p] && rd_need[p] && long_block) begin
                port_stall[p] = 1'b1;
            end
        end
    end

    // Stall composition: local cause, own-stage hazards, and anything stalled further down the pipe.
    always_comb begin
        hazard_stall = '0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int p = 0; p < NUM_READ; p++) begin
                if (rd_stage[p*STAGE_BITS +: STAGE_BITS] == STAGE_BITS'(s)) begin
                    hazard_stall[s] = hazard_stall[s] | port_stall[p];
                end
            end
        end
        stall        = '0;
        stall[DEPTH] = stall_req[DEPTH];
        for (int s = DEPTH - 1; s >= 0; s--) begin
            stall[s] = stall_req[s] | hazard_stall[s] | stall[s+1];
        end
    end

    // Tag advance: reset clears, a stalled stage holds, otherwise take upstream tag or a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 1; s <= DEPTH; s++) begin
                tags[s] <= '0;
            end
        end else begin
            for (int s = 2; s <= DEPTH; s++) begin
                if (!stall[s]) begin
                    tags[s] <= stall[s-1] ? '0 : tags[s-1];
                end
            end
            if (!stall[1]) begin
                tags[1] <= (stall[0] || flush_ex) ? '0 : id_tag;
            end
        end
    end

endmodule
